seq_mult_digit: RTL and testbench
=================================

Name: seq_mult_digit

Overview:
- Parametrised digit-serial multiplier, successor to the fixed 8-bit, 2-bit-per-cycle serial multiplier netlists.
- Latches full operands a (N bits) and b (N bits) through a valid/ready handshake.
- Consumes D bits of b per cycle over CC = N/D cycles, using a right-shifting 2N-bit accumulator.
- Returns the 2N-bit product through a valid/ready output handshake; sits in the mult netlist family as the synthesis source for the variable-N/CC sweeps.

Parameters:
- N, 8, operand width in bits; must be at least 2.
- D, 2, b digit width consumed per cycle; N % D == 0 is required, elaboration error otherwise.
- CC, N/D, derived local constant (cycles per multiply); not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept operands.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts the product.
- c  out  2N  product.
- busy  out  1  high in RUN.

Behaviour:
- Reset (rst == 0 at an edge):
  - state = IDLE; accumulator, a_reg, b_reg and digit counter are cleared.
  - Outputs: out_valid = 0, c = 0, busy = 0, in_ready = 1 from the following cycle.
  - Reset in any state, including mid-RUN, aborts the operation; no partial product is ever presented.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture a_reg = a and b_reg = b, clear acc and cnt, then go to RUN.
  - RUN: in_ready = 0, busy = 1, one digit per cycle.
    - digit = b_reg[D-1:0]
    - pp = a_reg * digit, width N+D
    - acc = ({pp + acc[2N-1:N], acc[N-1:0]}) >> D
    - b_reg >>= D; cnt++
    - When cnt == CC-1, go to DONE.
  - DONE: out_valid = 1, c = acc, held stable until out_ready. On out_valid & out_ready, go to IDLE.
- Latency and throughput:
  - Operands accepted at edge t produce out_valid = 1 after edge t+CC.
  - Minimum initiation interval is CC+2 cycles: there is no accept in DONE, even when out_ready = 1.
- Width rules (unsigned):
  - pp + acc upper half is below 2^(N+D), so no carry is lost.
  - The final acc equals a*b exactly, with no truncation.
- Boundaries:
  - D == N: CC = 1, single RUN cycle.
  - in_valid is ignored outside IDLE; the operands do not have to be held after acceptance.
  - out_ready while out_valid = 0 has no effect.
  - c retains its last value in IDLE/RUN; it is valid only when out_valid = 1.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined: a and b are two's complement.
  - a_reg is sign-extended within pp.
  - Digits 0..CC-2 are unsigned; the final digit (cnt == CC-1) is signed, so its MSB carries negative weight.
  - pp is computed as a signed (N+D)-bit value.
  - The accumulator upper-half add and the shift are arithmetic (sign-preserving).
  - c is the signed 2N-bit product.
- Undefined: purely unsigned datapath as above; no sign logic is synthesised.

Decomposition:
- Shared package mult_pkg holds:
  - state typedef mult_state_t {IDLE, RUN, DONE};
  - function cc_of(N, D);
  - the parameter legality check.
- One sub-module, mult_digit_pp: combinational N×D partial-product generator (signed variant under the macro), instantiated once.
- The FSM, counter and accumulator stay in the top-level module.

Test Plan:
- N=8, D=2, a=0xFF, b=0xFF accepted at edge 0 -> out_valid at edge 4, c=0xFE01; in_ready low through DONE.
- N=8, D=8, a=0x12, b=0x34 -> CC=1, out_valid after edge 1, c=0x03A8.
- N=8, D=2, a=0x00, b=0xA5, out_ready held low 5 cycles -> c=0x0000 stable and out_valid high throughout; a new in_valid is ignored until the handshake completes.
- rst driven low at the 2nd RUN cycle of a=0x7F, b=0x03 -> the next cycle is IDLE with out_valid=0, c=0; a following a=3, b=5 yields c=0x000F.
- Random back-to-back unsigned sweep, N ∈ {8,16}, D ∈ {1,2,4} -> every product matches the reference model; the interval between accepts is at least CC+2.
- SEQ_MULT_SIGNED_EN, N=8, D=2:
  - a=0x80, b=0x7F -> c=0xC080;
  - a=0xFF, b=0xFF -> c=0x0001.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and parameter helpers for the digit-serial multiplier family
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    function automatic int cc_of(input int n, input int d);
        return (d > 0) ? (n / d) : 1;
    endfunction

    function automatic bit params_ok(input int n, input int d);
        return (n >= 2) && (d >= 1) && (d <= n) && ((n % d) == 0);
    endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// rtl/mult_digit_pp.sv - combinational N x D partial product; SEQ_MULT_SIGNED_EN selects the two's complement variant
module mult_digit_pp
    import mult_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic [N-1:0]   a_i,
    input  logic [D-1:0]   digit_i,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic           signed_digit_i,
`endif
    output logic [N+D-1:0] pp_o
);

`ifdef SEQ_MULT_SIGNED_EN
    logic                 digit_sign;
    logic signed [N+D-1:0] a_ext;
    logic signed [N+D-1:0] digit_ext;

    // Only the most significant digit of b carries negative weight.
    assign digit_sign = signed_digit_i & digit_i[D-1];
    assign a_ext      = {{D{a_i[N-1]}}, a_i};
    assign digit_ext  = {{N{digit_sign}}, digit_i};
    assign pp_o       = a_ext * digit_ext;
`else
    assign pp_o = (N+D)'(a_i) * (N+D)'(digit_i);
`endif

endmodule

// File: rtl/seq_mult_digit.sv
// rtl/seq_mult_digit.sv - digit-serial multiplier with valid/ready handshakes; SEQ_MULT_SIGNED_EN enables signed operands
module seq_mult_digit
    import mult_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] c,
    output logic           busy
);

    localparam int CC = cc_of(N, D);
    localparam int CW = (CC > 1) ? $clog2(CC) : 1;

    if (!params_ok(N, D)) begin : g_bad_params
        $error("seq_mult_digit: N must be >= 2 and a multiple of D");
    end

    mult_state_t     state_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [2*N-1:0]  acc_q;
    logic [2*N-1:0]  acc_d;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [2*N-1:0]  c_q;

    logic            last_digit;
    logic [N+D-1:0]  pp;
    logic [N+D-1:0]  hi_ext;
    logic [N+D-1:0]  sum;

    assign last_digit = (cnt_q == CW'(CC - 1));

    mult_digit_pp #(
        .N (N),
        .D (D)
    ) u_pp (
        .a_i            (a_q),
        .digit_i        (b_q[D-1:0]),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_digit_i (last_digit),
`endif
        .pp_o           (pp)
    );

`ifdef SEQ_MULT_SIGNED_EN
    assign hi_ext = {{D{acc_q[2*N-1]}}, acc_q[2*N-1:N]};
`else
    assign hi_ext = {{D{1'b0}}, acc_q[2*N-1:N]};
`endif

    // The upper-half sum is N+D wide, so the shift below drops only finished low bits.
    assign sum   = pp + hi_ext;
    assign acc_d = (2*N)'({sum, acc_q[N-1:0]} >> D);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            c_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    b_q   <= b_q >> D;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_digit) begin
                        c_q         <= acc_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // No accept here even with out_ready high: IDLE must be revisited first.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign c         = c_q;

endmodule

// File: tb/tb_seq_mult_digit.sv
// tb/tb_seq_mult_digit.sv - self-checking bench over several N/D configurations; honours SEQ_MULT_SIGNED_EN
module tb_seq_mult_digit;

    localparam int NI = 7;

`ifdef SEQ_MULT_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    function automatic int n_of(input int k);
        case (k)
            0, 1, 2, 3: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic int d_of(input int k);
        case (k)
            0: return 2;
            1: return 8;
            2: return 1;
            3: return 4;
            4: return 2;
            5: return 4;
            default: return 1;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NI-1:0] in_valid_s  = '0;
    logic [NI-1:0] out_ready_s = '0;
    logic [NI-1:0] in_ready_s;
    logic [NI-1:0] out_valid_s;
    logic [NI-1:0] busy_s;
    logic [15:0]   a_s [NI];
    logic [15:0]   b_s [NI];
    logic [31:0]   c_s [NI];
    int            cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NG = n_of(g);
        localparam int DG = d_of(g);
        logic [2*NG-1:0] c_w;

        seq_mult_digit #(
            .N (NG),
            .D (DG)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .a         (NG'(a_s[g])),
            .b         (NG'(b_s[g])),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .c         (c_w),
            .busy      (busy_s[g])
        );

        assign c_s[g] = 32'(c_w);
    end

    int checks = 0;
    int errors = 0;
    int last_acc [NI];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer product of the operands interpreted at width n.
    function automatic logic [31:0] ref_mul(input int n, input logic [15:0] av, input logic [15:0] bv);
        longint sa;
        longint sb;
        longint p;
        longint mask_in;
        mask_in = (64'sd1 <<< n) - 1;
        sa = longint'(av) & mask_in;
        sb = longint'(bv) & mask_in;
        if (SIGNED_MODE && av[n-1]) sa = sa - (64'sd1 <<< n);
        if (SIGNED_MODE && bv[n-1]) sb = sb - (64'sd1 <<< n);
        p = sa * sb;
        return 32'(p & ((64'sd1 <<< (2*n)) - 1));
    endfunction

    task automatic xact(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input int hold, input logic [31:0] exp, input bit chk_ii);
        int waitc;
        int lat;
        int cc;
        cc = n_of(k) / d_of(k);
        waitc = 0;
        while (!in_ready_s[k] && waitc < 100) begin
            step();
            waitc++;
        end
        chk("in_ready_wait", 32'(in_ready_s[k]), 32'd1);
        a_s[k] = av;
        b_s[k] = bv;
        in_valid_s[k] = 1'b1;
        step();
        if (chk_ii) chk("accept_interval_ok", 32'((cyc - last_acc[k]) >= cc + 2), 32'd1);
        last_acc[k] = cyc;
        in_valid_s[k] = 1'b0;
        a_s[k] = 16'($urandom);
        b_s[k] = 16'($urandom);
        chk("busy_in_run", 32'(busy_s[k]), 32'd1);
        chk("in_ready_in_run", 32'(in_ready_s[k]), 32'd0);
        lat = 0;
        while (lat < 300) begin
            out_ready_s[k] = 1'($urandom);
            step();
            lat++;
            if (out_valid_s[k]) break;
        end
        out_ready_s[k] = 1'b0;
        chk("latency", 32'(lat), 32'(cc));
        chk("product", c_s[k], exp);
        chk("in_ready_in_done", 32'(in_ready_s[k]), 32'd0);
        chk("busy_in_done", 32'(busy_s[k]), 32'd0);
        in_valid_s[k] = 1'b1;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("out_valid_held", 32'(out_valid_s[k]), 32'd1);
            chk("product_held", c_s[k], exp);
            chk("in_ready_held", 32'(in_ready_s[k]), 32'd0);
        end
        out_ready_s[k] = 1'b1;
        step();
        out_ready_s[k] = 1'b0;
        in_valid_s[k] = 1'b0;
        chk("out_valid_after_hs", 32'(out_valid_s[k]), 32'd0);
        chk("in_ready_after_hs", 32'(in_ready_s[k]), 32'd1);
        chk("product_retained", c_s[k], exp);
    endtask

    typedef struct {
        int          k;
        logic [15:0] a;
        logic [15:0] b;
        int          hold;
        logic [31:0] c;
    } vec_t;

    vec_t tbl [7];

    initial begin
        for (int k = 0; k < NI; k++) begin
            a_s[k] = '0;
            b_s[k] = '0;
            last_acc[k] = 0;
        end

        tbl[0] = '{k: 0, a: 16'h00FF, b: 16'h00FF, hold: 0, c: SIGNED_MODE ? 32'h0001 : 32'hFE01};
        tbl[1] = '{k: 1, a: 16'h0012, b: 16'h0034, hold: 1, c: 32'h03A8};
        tbl[2] = '{k: 0, a: 16'h0000, b: 16'h00A5, hold: 5, c: 32'h0000};
        tbl[3] = '{k: 0, a: 16'h0080, b: 16'h007F, hold: 0, c: SIGNED_MODE ? 32'hC080 : 32'h3F80};
        tbl[4] = '{k: 4, a: 16'hFFFF, b: 16'hFFFF, hold: 2, c: SIGNED_MODE ? 32'h0000_0001 : 32'hFFFE_0001};
        tbl[5] = '{k: 2, a: 16'h00AB, b: 16'h00CD, hold: 0, c: SIGNED_MODE ? 32'h10EF : 32'h88EF};
        tbl[6] = '{k: 3, a: 16'h000F, b: 16'h0010, hold: 1, c: 32'h00F0};

        rst = 1'b0;
        step();
        step();
        for (int k = 0; k < NI; k++) begin
            chk("reset_out_valid", 32'(out_valid_s[k]), 32'd0);
            chk("reset_c", c_s[k], 32'd0);
            chk("reset_busy", 32'(busy_s[k]), 32'd0);
            chk("reset_in_ready", 32'(in_ready_s[k]), 32'd1);
        end
        rst = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            xact(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].c, 1'b0);
        end

        // Abort mid-RUN: reset lands on the second RUN cycle.
        a_s[0] = 16'h007F;
        b_s[0] = 16'h0003;
        in_valid_s[0] = 1'b1;
        step();
        in_valid_s[0] = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_out_valid", 32'(out_valid_s[0]), 32'd0);
        chk("abort_c", c_s[0], 32'd0);
        chk("abort_busy", 32'(busy_s[0]), 32'd0);
        chk("abort_in_ready", 32'(in_ready_s[0]), 32'd1);
        xact(0, 16'h0003, 16'h0005, 0, 32'h000F, 1'b0);

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 20; i++) begin
                logic [15:0] m;
                logic [15:0] av;
                logic [15:0] bv;
                int          hold;
                m    = (n_of(k) == 16) ? 16'hFFFF : 16'h00FF;
                av   = 16'($urandom) & m;
                bv   = 16'($urandom) & m;
                hold = (i % 4 == 0) ? int'($urandom_range(0, 3)) : 0;
                xact(k, av, bv, hold, ref_mul(n_of(k), av, bv), i > 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
